pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 64: payload width in bits, legal range 1..1024.
REQ-002 SHALL have parameter CNT_W, default 16: width of the stall counter.
REQ-003 SHALL have parameter ZERO_ON_FLUSH, default 1: 1 = flush/reset zeroes data registers, 0 = flush clears only valid state.
REQ-004 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port nRST  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  upstream payload valid.
REQ-007 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-008 SHALL have port in_ready  output  1  stage accepts in_data this cycle.
REQ-009 SHALL have port out_valid  output  1  out_data valid.
REQ-010 SHALL have port out_data  output  DATA_W  downstream payload.
REQ-011 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 SHALL have port flush  input  1  synchronous squash of all held entries.
REQ-013 SHALL have port occupancy  output  2  number of held entries, 0..2.
REQ-014 SHALL have port stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-015 SHALL hold a main register and one skid register; state is EMPTY, ONE or TWO.
REQ-016 SHALL decode in_ready = (state != TWO) from state registers only; no combinational path from out_ready to in_ready.
REQ-017 SHALL decode out_valid = (state != EMPTY) and drive out_data from the main register.
REQ-018 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-019 EMPTY: in_fire loads main and moves to ONE; otherwise stay.
REQ-020 ONE: in_fire & out_fire loads main from in_data and stays ONE; in_fire alone loads skid and moves to TWO; out_fire alone moves to EMPTY.
REQ-021 TWO: out_fire copies skid into main and moves to ONE; otherwise hold; in_valid is ignored.
REQ-022 SHALL give latency 1 cycle from in_fire to out_valid when EMPTY; throughput 1 item/cycle when out_ready stays high.
REQ-023 SHALL preserve FIFO order: no payload is lost, duplicated or reordered.
REQ-024 flush SHALL have priority over all events: next state EMPTY, and an input presented in the same cycle is dropped.
REQ-025 With ZERO_ON_FLUSH=1, flush SHALL zero main and skid; with 0, data registers SHALL hold.
REQ-026 A flush cycle SHALL still count as a transfer when out_fire=1 in that cycle; the downstream sees that item.
REQ-027 occupancy SHALL encode EMPTY=0, ONE=1, TWO=2.
REQ-028 stall_cnt SHALL increment when out_valid & !out_ready and saturate at 2^CNT_W-1; flush SHALL NOT clear it.

Reset
REQ-029 nRST low SHALL immediately force state EMPTY, main=0, skid=0 (regardless of ZERO_ON_FLUSH), stall_cnt=0.
REQ-030 During and after reset, outputs SHALL be out_valid=0, in_ready=1, occupancy=0, out_data=0.
REQ-031 Reset asserted mid-transfer SHALL discard all held entries; no partial update after release.

Structure
REQ-032 The state enum pstage_state_t (EMPTY, ONE, TWO) SHALL live in cpu_types_pkg.
REQ-033 SHALL be a single module with no sub-modules; the saturating counter is inline.
REQ-034 Every output SHALL derive from registers only.

Verification
REQ-035 Reset then in_valid=1, in_data=0xA5 with out_ready=1 -> out_valid=1, out_data=0xA5 next cycle; occupancy=1.
REQ-036 out_ready=0 while sending 0x1 then 0x2 -> TWO, in_ready=0, stall_cnt counts up; out_ready=1 -> 0x1 then 0x2 emitted in order, in_ready=1 after the first pop.
REQ-037 Streaming 0..99 with out_ready=1 every cycle -> 100 outputs in order on back-to-back cycles, occupancy never 2.
REQ-038 flush with state TWO and in_valid=1 (in_data=0x7) -> next cycle EMPTY, out_valid=0, 0x7 never emitted; data=0 when ZERO_ON_FLUSH=1 and unchanged when 0.
REQ-039 CNT_W=2, out_ready held 0 for 6 cycles -> stall_cnt 1,2,3,3,3 and stays 3.
REQ-040 nRST pulsed low in TWO mid-cycle -> outputs immediately out_valid=0, in_ready=1, out_data=0, stall_cnt=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline stage: the skid-buffer occupancy state.
package cpu_types_pkg;

  // Encoding doubles as the held-entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pstage_state_t;

  function automatic logic [1:0] pstage_occupancy(pstage_state_t s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle around one pipeline stage (upstream and downstream sides).
interface pipe_stage_skid_if #(
  parameter int unsigned DATA_W = 64
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  // The stage itself.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );

  // The environment driving and draining the stage.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline stage: registered in_ready/out_valid, FIFO order,
// synchronous flush and a saturating downstream-stall counter.
module pipe_stage_skid
  import cpu_types_pkg::*;
#(
  parameter int unsigned DATA_W        = 64,
  parameter int unsigned CNT_W         = 16,
  parameter bit          ZERO_ON_FLUSH = 1'b1
) (
  input  logic             CLK,
  input  logic             nRST,
  pipe_stage_skid_if.slave bus,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  pstage_state_t     state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic in_ready_w;
  logic out_valid_w;
  logic in_fire;
  logic out_fire;

  // Handshake outputs decode state only, so out_ready never reaches in_ready.
  assign in_ready_w  = (state_q != TWO);
  assign out_valid_w = (state_q != EMPTY);
  assign in_fire     = bus.in_valid & in_ready_w;
  assign out_fire    = out_valid_w & bus.out_ready;

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = main_q;
  assign occupancy     = pstage_occupancy(state_q);
  assign stall_cnt     = stall_cnt_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      if (ZERO_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = bus.in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = bus.in_data;
          end else if (in_fire) begin
            skid_d  = bus.in_data;
            state_d = TWO;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_w && !bus.out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: two stages share stimulus, A (CNT_W=2, zero on flush) and B (CNT_W=16, hold).
module tb_pipe_stage_skid;
  localparam int unsigned DW = 16;

  logic          CLK;
  logic          nRST;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          flush;
  logic [1:0]    occ_a, occ_b;
  logic [1:0]    stall_a;
  logic [15:0]   stall_b;

  int checks = 0;
  int errors = 0;

  pipe_stage_skid_if #(.DATA_W(DW)) if_a ();
  pipe_stage_skid_if #(.DATA_W(DW)) if_b ();

  assign if_a.in_valid  = in_valid;
  assign if_a.in_data   = in_data;
  assign if_a.out_ready = out_ready;
  assign if_b.in_valid  = in_valid;
  assign if_b.in_data   = in_data;
  assign if_b.out_ready = out_ready;

  pipe_stage_skid #(.DATA_W(DW), .CNT_W(2), .ZERO_ON_FLUSH(1'b1)) dut_a (
    .CLK       (CLK),
    .nRST      (nRST),
    .bus       (if_a),
    .flush     (flush),
    .occupancy (occ_a),
    .stall_cnt (stall_a)
  );

  pipe_stage_skid #(.DATA_W(DW), .CNT_W(16), .ZERO_ON_FLUSH(1'b0)) dut_b (
    .CLK       (CLK),
    .nRST      (nRST),
    .bus       (if_b),
    .flush     (flush),
    .occupancy (occ_b),
    .stall_cnt (stall_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " a.out_valid"}, 32'(if_a.out_valid), 32'd0);
    chk({tag, " a.in_ready"},  32'(if_a.in_ready),  32'd1);
    chk({tag, " a.occ"},       32'(occ_a),          32'd0);
    chk({tag, " a.out_data"},  32'(if_a.out_data),  32'd0);
    chk({tag, " a.stall"},     32'(stall_a),        32'd0);
    chk({tag, " b.out_data"},  32'(if_b.out_data),  32'd0);
    chk({tag, " b.stall"},     32'(stall_b),        32'd0);
  endtask

  initial begin
    nRST = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_idle("reset");
    @(negedge CLK) nRST = 1'b1;
    tick();

    // Single item, downstream ready.
    in_valid = 1'b1; in_data = 16'h00A5; out_ready = 1'b1;
    tick();
    chk("single valid", 32'(if_a.out_valid), 32'd1);
    chk("single data",  32'(if_a.out_data),  32'h00A5);
    chk("single occ",   32'(occ_a),          32'd1);
    in_valid = 1'b0;
    tick();
    chk("single drain occ", 32'(occ_a), 32'd0);

    // Back-pressure fills the skid; a third offer is ignored.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0001;
    tick();
    chk("bp occ1",   32'(occ_a),   32'd1);
    chk("bp stall0", 32'(stall_a), 32'd0);
    in_data = 16'h0002;
    tick();
    chk("bp occ2",     32'(occ_a),          32'd2);
    chk("bp in_ready", 32'(if_a.in_ready),  32'd0);
    chk("bp stall1",   32'(stall_a),        32'd1);
    in_data = 16'h0003;
    tick();
    chk("bp stall2",   32'(stall_a),        32'd2);
    chk("bp head",     32'(if_a.out_data),  32'h0001);
    chk("bp hold occ", 32'(occ_b),          32'd2);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp pop2 data", 32'(if_a.out_data), 32'h0002);
    chk("bp pop ready", 32'(if_a.in_ready), 32'd1);
    chk("bp pop occ",   32'(occ_a),         32'd1);
    tick();
    chk("bp empty",      32'(if_a.out_valid), 32'd0);
    chk("bp stall kept", 32'(stall_b),        32'd2);

    // Streaming at full rate: item i visible the cycle after it is offered.
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = 16'(i);
      tick();
      chk("stream data", {15'd0, if_a.out_valid, if_a.out_data}, 32'h0001_0000 | 32'(i));
      chk("stream occ",  32'(occ_a == 2'd2), 32'd0);
    end
    in_valid = 1'b0;
    tick();
    chk("stream drained", 32'(if_a.out_valid), 32'd0);

    // Flush in TWO with a fresh input offered the same cycle.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0011;
    tick();
    in_data = 16'h0022;
    tick();
    chk("fl occ2", 32'(occ_a), 32'd2);
    in_data = 16'h0007; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl valid",    32'(if_a.out_valid), 32'd0);
    chk("fl occ",      32'(occ_b),          32'd0);
    chk("fl a zero",   32'(if_a.out_data),  32'h0000);
    chk("fl b hold",   32'(if_b.out_data),  32'h0011);
    chk("fl a stall",  32'(stall_a),        32'd3);
    chk("fl b stall",  32'(stall_b),        32'd4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl no 0x7", 32'(if_a.out_valid | if_b.out_valid), 32'd0);
    end

    // Asynchronous reset between edges while holding two entries.
    in_valid = 1'b1; in_data = 16'h0033;
    tick();
    in_data = 16'h0044;
    tick();
    chk("rst pre occ", 32'(occ_a), 32'd2);
    in_valid = 1'b0;
    #2 nRST = 1'b0;
    #1;
    chk_idle("midrst");
    @(negedge CLK) nRST = 1'b1;
    tick();
    chk("post rst occ", 32'(occ_b), 32'd0);

    // Counter saturation with CNT_W=2 over six stalled cycles.
    in_valid = 1'b1; in_data = 16'h0055;
    tick();
    in_valid = 1'b0;
    chk("sat start", 32'(stall_a), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("sat a", 32'(stall_a), (k < 3) ? 32'(k) : 32'd3);
      chk("sat b", 32'(stall_b), 32'(k));
    end

    // Flush coinciding with a transfer: the head item is still delivered.
    out_ready = 1'b1; flush = 1'b1;
    chk("flxfer seen", {15'd0, if_a.out_valid, if_a.out_data}, 32'h0001_0055);
    tick();
    flush = 1'b0;
    chk("flxfer empty", 32'(if_a.out_valid), 32'd0);
    chk("flxfer stall", 32'(stall_a),        32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
